fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch sequencer sitting directly downstream of the 16-bit PC register; it also closes the loop by driving the PC's `in` and `PCWrite` inputs.
- Reads current PC, runs a req/ack handshake with variable-latency instruction memory and latches the returned word into an instruction register.
- Presents the instruction to decode with a valid/ready handshake.
- Advances the PC sequentially, or redirects it on branch/jump and squashes any in-flight fetch.

Parameters:
- DATA_W, 16, width of PC, address and instruction word.
- PC_STEP, 1, increment added to PC after each fetch (word-addressed memory).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc  in  DATA_W  current PC (from PC register `out`).
- pc_next  out  DATA_W  next PC value (to PC register `in`).
- pc_write  out  1  PC write enable (to PC register `PCWrite`); combinational.
- mem_req  out  1  instruction-memory request; registered.
- mem_addr  out  DATA_W  request address; registered, stable while mem_req=1.
- mem_ack  in  1  memory completes request; mem_rdata valid this cycle.
- mem_rdata  in  DATA_W  fetched instruction word.
- ir  out  DATA_W  instruction register to decode.
- ir_valid  out  1  ir holds an unconsumed instruction.
- ir_ready  in  1  decode accepts ir this cycle.
- redirect  in  1  branch/jump taken; 1-cycle pulse or level.
- redirect_target  in  DATA_W  new PC when redirect=1.

Behaviour:
Reset (async, active-high):
- state=IDLE; mem_req=0, mem_addr=0, ir=0, ir_valid=0.
- pc_write=0 and pc_next=0 while reset is asserted.

States:
- IDLE
  - If redirect=0: mem_addr<=pc, go to WAIT (mem_req=1 next cycle).
  - If redirect=1: no issue, stay IDLE. The PC updates this edge; the issue happens next cycle from the new pc.
- WAIT (mem_req=1)
  - mem_ack & !redirect: ir<=mem_rdata, ir_valid<=1, pc_write=1, pc_next=mem_addr+PC_STEP (mod 2^DATA_W; 16'hFFFF wraps to 0); go to HOLD.
  - redirect & mem_ack: data discarded, ir unchanged, go to IDLE.
  - redirect & !mem_ack: go to DRAIN.
  - neither: stay in WAIT.
- DRAIN (mem_req=1)
  - The request must not be abandoned: mem_req stays high and mem_addr stays unchanged until mem_ack.
  - On mem_ack: discard data, go to IDLE.
- HOLD (ir_valid=1)
  - ir and ir_valid are held until ir_ready=1.
  - ir_ready=1: ir_valid<=0, go to IDLE.
  - redirect=1 (with or without ir_ready): ir_valid<=0, go to IDLE; the stale instruction is never consumed.

Redirect, any state:
- pc_write=1, pc_next=redirect_target, same cycle.
- Redirect takes priority over the sequential increment.
- Back-to-back redirects: the last one wins.

Timing and invariants:
- Throughput: ack in cycle N, ir_valid in N+1; if ir_ready in N+1, IDLE in N+2 and mem_req in N+3.
- Minimum 3 cycles/instruction with 0-wait memory (ack in first mem_req cycle).
- mem_ack while not in WAIT/DRAIN is ignored.
- Exactly one pc_write per successful fetch.
- ir changes only on a successful WAIT ack.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs fetch_count[15:0] and squash_count[15:0], both reset to 0 and saturating at 16'hFFFF.
  - fetch_count increments on each successful WAIT ack.
  - squash_count increments on each redirect that discards a fetch: WAIT→DRAIN, WAIT redirect with ack, or HOLD redirect.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg: state enum (IDLE, WAIT, DRAIN, HOLD), DATA_W default, PC_STEP default, counter width.
- Core FSM stays flat in fetch_unit.
- One natural sub-module, fetch_perf_ctr: a saturating counter, instantiated twice, only under FETCH_PERF_EN.

Test Plan:
1. Reset mid-WAIT with mem_req=1 → mem_req, ir_valid and pc_write all 0 immediately (async); after release, IDLE issues mem_addr=pc.
2. pc=16'h0010, 0-wait memory returns 16'hA5A5 in the first mem_req cycle, ir_ready=1 → ir=16'hA5A5 and ir_valid 1 cycle after ack; pc_write pulsed once with pc_next=16'h0011; next mem_req at ack+3.
3. pc=16'hFFFF, memory returns 16'h1234 after 3 wait cycles → mem_addr stable for 4 cycles; pc_next=16'h0000 on the ack cycle.
4. Redirect to 16'h0200 during WAIT at wait-cycle 1, ack 2 cycles later → pc_write/pc_next=16'h0200 in the redirect cycle; mem_req held through ack; ir unchanged; ir_valid stays 0; next mem_addr=16'h0200.
5. HOLD with ir_ready=0 for 5 cycles, then redirect to 16'h0040 → ir stable for 5 cycles, ir_valid drops after redirect, next fetch from 16'h0040; with FETCH_PERF_EN, squash_count=1.
6. Redirect and mem_ack in the same WAIT cycle (target 16'h0080) → pc_next=16'h0080, no sequential pc_write, data discarded, state IDLE, next mem_addr=16'h0080.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM state
// encoding, default datapath width, PC increment and counter width.
package fetch_pkg;

  localparam int FETCH_DATA_W  = 16;
  localparam int FETCH_PC_STEP = 1;
  localparam int PERF_CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Saturating event counter used for fetch statistics. Holds at all-ones
// instead of wrapping so a long run never reports a small count.
module fetch_perf_ctr
  import fetch_pkg::*;
#(
  parameter int W = PERF_CNT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step by one unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer. Issues one memory request per instruction
// from the current PC, latches the returned word into the instruction
// register, hands it to decode, and drives the PC register's write port
// (sequential increment or branch/jump redirect).
// Optional build macro FETCH_PERF_EN adds fetch_count/squash_count outputs.
//
// Handshakes:
//   memory : mem_req/mem_addr are registered and held until mem_ack; once a
//            request is raised it is never withdrawn before its ack, even if
//            a redirect makes the returned data useless (DRAIN).
//   decode : ir/ir_valid are held stable while ir_valid=1 and ir_ready=0;
//            the instruction is consumed in a cycle where both are 1.
//            A redirect drops ir_valid without the instruction being consumed.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DATA_W  = FETCH_DATA_W,
  parameter int PC_STEP = FETCH_PC_STEP
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     pc,
  output logic [DATA_W-1:0]     pc_next,
  output logic                  pc_write,
  output logic                  mem_req,
  output logic [DATA_W-1:0]     mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [DATA_W-1:0]     ir,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  input  logic                  redirect,
  input  logic [DATA_W-1:0]     redirect_target,
`ifdef FETCH_PERF_EN
  output logic [PERF_CNT_W-1:0] fetch_count,
  output logic [PERF_CNT_W-1:0] squash_count,
`endif
  output logic [1:0]            dbg_state
);

  localparam logic [DATA_W-1:0] STEP = DATA_W'(PC_STEP);

  fetch_state_e      state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              fetch_done;

  // Next-state and datapath updates for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    fetch_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A redirect this cycle rewrites the PC; issue from the new PC next cycle.
        if (!redirect) begin
          mem_addr_d = pc;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          state_d = mem_ack ? ST_IDLE : ST_DRAIN;
        end else if (mem_ack) begin
          fetch_done = 1'b1;
          ir_d       = mem_rdata;
          ir_valid_d = 1'b1;
          state_d    = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (mem_ack) state_d = ST_IDLE;
      end
      ST_HOLD: begin
        if (redirect || ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    mem_req_d = (state_d == ST_WAIT) || (state_d == ST_DRAIN);
  end

  // PC write port: redirect wins over the sequential step; silent in reset.
  always_comb begin
    pc_write = 1'b0;
    pc_next  = '0;
    if (!reset) begin
      if (redirect) begin
        pc_write = 1'b1;
        pc_next  = redirect_target;
      end else if (fetch_done) begin
        pc_write = 1'b1;
        pc_next  = mem_addr_q + STEP;
      end
    end
  end

  // FSM and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign dbg_state = state_q;

`ifdef FETCH_PERF_EN
  // A redirect discards work whenever a fetch is live or an instruction is held.
  logic squash;
  assign squash = redirect && ((state_q == ST_WAIT) || (state_q == ST_HOLD));

  fetch_perf_ctr #(.W(PERF_CNT_W)) u_fetch_ctr (
    .clock (clock),
    .reset (reset),
    .inc   (fetch_done),
    .count (fetch_count)
  );

  fetch_perf_ctr #(.W(PERF_CNT_W)) u_squash_ctr (
    .clock (clock),
    .reset (reset),
    .inc   (squash),
    .count (squash_count)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a stand-in PC register, a transaction-level model
// (request outstanding / squashed / instruction held) checked every cycle,
// and directed vectors with hand-computed literal expectations.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pc = '0;
  logic [W-1:0] pc_next;
  logic         pc_write;
  logic         mem_req;
  logic [W-1:0] mem_addr;
  logic         mem_ack;
  logic [W-1:0] mem_rdata;
  logic [W-1:0] ir;
  logic         ir_valid;
  logic         ir_ready;
  logic         redirect;
  logic [W-1:0] redirect_target;
  logic [1:0]   dbg_state;
`ifdef FETCH_PERF_EN
  logic [15:0]  fetch_count;
  logic [15:0]  squash_count;
`endif

  logic         pc_load;
  logic [W-1:0] pc_load_val;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fetch_unit #(.DATA_W(W), .PC_STEP(1)) dut (
    .clock           (clk),
    .reset           (rst),
    .pc              (pc),
    .pc_next         (pc_next),
    .pc_write        (pc_write),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .ir              (ir),
    .ir_valid        (ir_valid),
    .ir_ready        (ir_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
`ifdef FETCH_PERF_EN
    .fetch_count     (fetch_count),
    .squash_count    (squash_count),
`endif
    .dbg_state       (dbg_state)
  );

  // Stand-in PC register; the bench can force a value with pc_load.
  always @(posedge clk) begin
    if (pc_load)       pc <= pc_load_val;
    else if (pc_write) pc <= pc_next;
  end

  // ---------------- behavioural model ----------------
  logic         m_busy = 1'b0;  // a memory request is outstanding
  logic         m_sq   = 1'b0;  // outstanding request has been squashed
  logic         m_irv  = 1'b0;  // an instruction is waiting for decode
  logic [W-1:0] m_addr = '0;
  logic [W-1:0] m_ir   = '0;
  logic [15:0]  m_fc   = '0;
  logic [15:0]  m_sc   = '0;

  initial forever begin
    logic o_busy, o_sq, o_irv, ok;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_busy = 1'b0; m_sq = 1'b0; m_irv = 1'b0;
      m_addr = '0;   m_ir = '0;   m_fc  = '0; m_sc = '0;
    end else begin
      o_busy = m_busy; o_sq = m_sq; o_irv = m_irv;
      ok = o_busy && !o_sq && mem_ack && !redirect;
      if (redirect && ((o_busy && !o_sq) || o_irv) && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      m_irv = o_irv && !(ir_ready || redirect);
      if (ok) begin
        m_irv = 1'b1;
        m_ir  = mem_rdata;
        if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
      end
      if (o_busy && mem_ack) begin
        m_busy = 1'b0; m_sq = 1'b0;
      end else if (o_busy && redirect) begin
        m_sq = 1'b1;
      end
      if (!o_busy && !o_irv && !redirect) begin
        m_busy = 1'b1; m_addr = pc;
      end
    end
  end

  // ---------------- scoreboard ----------------
  localparam int S_REQ = 0, S_ADDR = 1, S_IR = 2, S_IRV = 3, S_PW = 4,
                 S_PN = 5, S_ST = 6, S_FC = 7, S_SC = 8;

  logic [W-1:0] exp_q[$];
  int           sig_q[$];

  task automatic expect_lit(input int s, input logic [W-1:0] v);
    sig_q.push_back(s);
    exp_q.push_back(v);
  endtask

  function automatic string sig_name(input int s);
    case (s)
      S_REQ:   return "lit_mem_req";
      S_ADDR:  return "lit_mem_addr";
      S_IR:    return "lit_ir";
      S_IRV:   return "lit_ir_valid";
      S_PW:    return "lit_pc_write";
      S_PN:    return "lit_pc_next";
      S_ST:    return "lit_state";
      S_FC:    return "lit_fetch_count";
      default: return "lit_squash_count";
    endcase
  endfunction

  function automatic logic [W-1:0] sig_val(input int s);
    case (s)
      S_REQ:   return {15'd0, mem_req};
      S_ADDR:  return mem_addr;
      S_IR:    return ir;
      S_IRV:   return {15'd0, ir_valid};
      S_PW:    return {15'd0, pc_write};
      S_PN:    return pc_next;
      S_ST:    return {14'd0, dbg_state};
`ifdef FETCH_PERF_EN
      S_FC:    return fetch_count;
      S_SC:    return squash_count;
`endif
      default: return '0;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Compare process: model every cycle out of reset, then pending literals.
  initial forever begin
    logic         exp_pw;
    logic [W-1:0] exp_pn;
    @(negedge clk);
    if (!rst) begin
      exp_pw = redirect || (m_busy && !m_sq && mem_ack);
      exp_pn = redirect ? redirect_target : m_addr + 16'd1;
      check("mdl_mem_req",  {15'd0, mem_req},  {15'd0, m_busy});
      if (m_busy) check("mdl_mem_addr", mem_addr, m_addr);
      check("mdl_ir",       ir,                m_ir);
      check("mdl_ir_valid", {15'd0, ir_valid}, {15'd0, m_irv});
      check("mdl_pc_write", {15'd0, pc_write}, {15'd0, exp_pw});
      if (exp_pw) check("mdl_pc_next", pc_next, exp_pn);
`ifdef FETCH_PERF_EN
      check("mdl_fetch_count",  fetch_count,  m_fc);
      check("mdl_squash_count", squash_count, m_sc);
`endif
    end
    while (exp_q.size() > 0) begin
      int           s;
      logic [W-1:0] e;
      s = sig_q.pop_front();
      e = exp_q.pop_front();
      check(sig_name(s), sig_val(s), e);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic perf_lit(input logic [15:0] fc, input logic [15:0] sc);
`ifdef FETCH_PERF_EN
    expect_lit(S_FC, fc);
    expect_lit(S_SC, sc);
`else
    if (fc == 16'hFFFF && sc == 16'hFFFF) expect_lit(S_FC, 16'h0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; ir_ready = 1'b0;
    redirect = 1'b0; redirect_target = '0;
    pc_load = 1'b1; pc_load_val = 16'h0100;

    // Reset state; a redirect during reset must not write the PC.
    cyc();
    pc_load = 1'b0; redirect = 1'b1; redirect_target = 16'h1234;
    expect_lit(S_REQ, 0); expect_lit(S_ADDR, 0); expect_lit(S_IR, 0);
    expect_lit(S_IRV, 0); expect_lit(S_PW, 0);   expect_lit(S_PN, 0);
    expect_lit(S_ST, 16'(ST_IDLE));
    cyc();
    rst = 1'b0; redirect = 1'b0;
    expect_lit(S_ST, 16'(ST_IDLE)); expect_lit(S_REQ, 0);
    cyc();
    expect_lit(S_REQ, 1); expect_lit(S_ADDR, 16'h0100); expect_lit(S_ST, 16'(ST_WAIT));
    cyc();
    // Async reset mid-WAIT, with an ack arriving in the same cycle.
    cyc();
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    pc_load = 1'b1; pc_load_val = 16'h0010;
    expect_lit(S_REQ, 0); expect_lit(S_IRV, 0); expect_lit(S_PW, 0);
    expect_lit(S_ST, 16'(ST_IDLE));
    cyc();
    rst = 1'b0; mem_ack = 1'b0; pc_load = 1'b0;
    expect_lit(S_REQ, 0);

    // Zero-wait fetch from 0x0010, decode ready immediately.
    cyc();
    expect_lit(S_REQ, 1); expect_lit(S_ADDR, 16'h0010);
    mem_ack = 1'b1; mem_rdata = 16'hA5A5;
    expect_lit(S_PW, 1); expect_lit(S_PN, 16'h0011); expect_lit(S_IRV, 0);
    cyc();
    mem_ack = 1'b0; ir_ready = 1'b1;
    expect_lit(S_IR, 16'hA5A5); expect_lit(S_IRV, 1); expect_lit(S_PW, 0);
    expect_lit(S_REQ, 0); expect_lit(S_ST, 16'(ST_HOLD));
    cyc();
    ir_ready = 1'b0;
    expect_lit(S_IRV, 0); expect_lit(S_REQ, 0); expect_lit(S_ST, 16'(ST_IDLE));
    cyc();
    // Next request three cycles after the ack.
    expect_lit(S_REQ, 1); expect_lit(S_ADDR, 16'h0011);
    mem_ack = 1'b1; mem_rdata = 16'h2222; pc_load = 1'b1; pc_load_val = 16'hFFFF;
    expect_lit(S_PN, 16'h0012);
    cyc();
    mem_ack = 1'b0; pc_load = 1'b0; ir_ready = 1'b1;
    expect_lit(S_IR, 16'h2222);
    cyc();
    ir_ready = 1'b0;

    // Fetch from 0xFFFF with three wait cycles; PC wraps to 0.
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_lit(S_REQ, 1); expect_lit(S_ADDR, 16'hFFFF); expect_lit(S_PW, 0);
    end
    cyc();
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    expect_lit(S_REQ, 1); expect_lit(S_ADDR, 16'hFFFF);
    expect_lit(S_PW, 1);  expect_lit(S_PN, 16'h0000);
    cyc();
    mem_ack = 1'b0; ir_ready = 1'b1;
    expect_lit(S_IR, 16'h1234); expect_lit(S_IRV, 1);
    cyc();
    ir_ready = 1'b0;

    // Redirect to 0x0200 in the second WAIT cycle; ack arrives two cycles later.
    cyc();
    expect_lit(S_REQ, 1); expect_lit(S_ADDR, 16'h0000);
    cyc();
    redirect = 1'b1; redirect_target = 16'h0200;
    expect_lit(S_PW, 1); expect_lit(S_PN, 16'h0200);
    cyc();
    redirect = 1'b0;
    expect_lit(S_REQ, 1); expect_lit(S_ADDR, 16'h0000); expect_lit(S_PW, 0);
    expect_lit(S_ST, 16'(ST_DRAIN));
    cyc();
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    expect_lit(S_REQ, 1); expect_lit(S_ADDR, 16'h0000); expect_lit(S_PW, 0);
    cyc();
    mem_ack = 1'b0;
    expect_lit(S_IR, 16'h1234); expect_lit(S_IRV, 0); expect_lit(S_REQ, 0);
    expect_lit(S_ST, 16'(ST_IDLE));

    // Fetch from 0x0200, then hold it 5 cycles and redirect to 0x0040.
    cyc();
    expect_lit(S_REQ, 1); expect_lit(S_ADDR, 16'h0200);
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    expect_lit(S_PN, 16'h0201);
    cyc();
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_lit(S_IR, 16'h5A5A); expect_lit(S_IRV, 1);
      cyc();
    end
    redirect = 1'b1; redirect_target = 16'h0040;
    expect_lit(S_PW, 1); expect_lit(S_PN, 16'h0040); expect_lit(S_IRV, 1);
    cyc();
    redirect = 1'b0;
    expect_lit(S_IRV, 0); expect_lit(S_IR, 16'h5A5A);
    // Four good fetches so far; squashes: DRAIN redirect and HOLD redirect.
    perf_lit(16'd4, 16'd2);

    // Redirect to 0x0080 together with the ack.
    cyc();
    expect_lit(S_REQ, 1); expect_lit(S_ADDR, 16'h0040);
    redirect = 1'b1; redirect_target = 16'h0080; mem_ack = 1'b1; mem_rdata = 16'h7777;
    expect_lit(S_PW, 1); expect_lit(S_PN, 16'h0080);
    cyc();
    redirect = 1'b0; mem_ack = 1'b0;
    expect_lit(S_ST, 16'(ST_IDLE)); expect_lit(S_IR, 16'h5A5A);
    expect_lit(S_IRV, 0); expect_lit(S_REQ, 0);
    perf_lit(16'd4, 16'd3);

    // Back-to-back redirects during WAIT/DRAIN: the last target wins.
    cyc();
    expect_lit(S_REQ, 1); expect_lit(S_ADDR, 16'h0080);
    redirect = 1'b1; redirect_target = 16'h0300;
    expect_lit(S_PN, 16'h0300);
    cyc();
    redirect_target = 16'h0400;
    expect_lit(S_ST, 16'(ST_DRAIN)); expect_lit(S_PN, 16'h0400); expect_lit(S_ADDR, 16'h0080);
    cyc();
    redirect = 1'b0; mem_ack = 1'b1;
    expect_lit(S_PW, 0); expect_lit(S_REQ, 1);
    cyc();
    // Redirect while IDLE: no issue this cycle.
    mem_ack = 1'b0; redirect = 1'b1; redirect_target = 16'h0500;
    expect_lit(S_ST, 16'(ST_IDLE)); expect_lit(S_PW, 1); expect_lit(S_PN, 16'h0500);
    cyc();
    // Stray ack while IDLE is ignored.
    redirect = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h9999;
    expect_lit(S_ST, 16'(ST_IDLE)); expect_lit(S_REQ, 0); expect_lit(S_PW, 0);
    cyc();
    mem_rdata = 16'h4321;
    expect_lit(S_REQ, 1); expect_lit(S_ADDR, 16'h0500);
    expect_lit(S_PW, 1);  expect_lit(S_PN, 16'h0501);
    perf_lit(16'd4, 16'd4);
    cyc();
    mem_ack = 1'b0; ir_ready = 1'b1;
    expect_lit(S_IR, 16'h4321); expect_lit(S_IRV, 1);
    perf_lit(16'd5, 16'd4);
    cyc();
    ir_ready = 1'b0;
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
